serial_subtractor: RTL

Multi-cycle, parametrised successor to the single-bit full subtractor. It computes d = a − b − barrow_in on WIDTH-bit unsigned operands, DIGIT bits per clock, LSB digit first, with a registered borrow chain between digits. A start/busy/done handshake makes it the shared subtract engine for datapath blocks that can trade latency for area.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/serial_subtractor_sub_digit.sv | 30 +++
 rtl/serial_subtractor.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the serial subtractor: FSM state encoding and counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(n)), never less than 1 so a single-step counter still has a bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit a - b - bin as a ripple of single-bit full-subtract cells.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; also exposes the borrow into the top bit for overflow detection.
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout,
  output logic             bmsb
);

  logic [DIGIT:0] bc;

  always_comb begin
    diff  = '0;
    bc    = '0;
    bc[0] = bin;
    for (int i = 0; i < DIGIT; i++) begin
      diff[i]  = a[i] ^ b[i] ^ bc[i];
      bc[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bc[i]);
    end
  end

  assign bout = bc[DIGIT];
  assign bmsb = bc[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial d = a - b - barrow_in, DIGIT bits per clock, LSB first; SERIAL_SUB_OVF_EN adds ovf.
// Latency: WIDTH/DIGIT cycles from the accepting edge to the done pulse.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted back-to-back.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             barrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             barrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = clog2_min1(STEPS);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic             br;
  logic             accept, last;
  logic [DIGIT-1:0] dig_diff;
  logic             dig_bout, dig_bmsb;
  logic [WIDTH+DIGIT-1:0] res_cat;

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .bin  (br),
    .diff (dig_diff),
    .bout (dig_bout),
    .bmsb (dig_bmsb)
  );

  // New digit enters at the top; after STEPS shifts the LSB digit sits at bit 0
  assign res_cat = {dig_diff, res_sr};
  assign res_nxt = res_cat[WIDTH+DIGIT-1:DIGIT];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (start) accept = 1'b1;
      RUN: begin
        if (cnt == CW'(STEPS - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) accept = 1'b1;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) state_nxt = RUN;
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      d      <= '0;
      barrow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sr <= a;
        b_sr <= b;
        br   <= barrow_in;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> DIGIT;
        b_sr   <= b_sr >> DIGIT;
        res_sr <= res_nxt;
        br     <= dig_bout;
        cnt    <= last ? '0 : cnt + 1'b1;
        if (last) begin
          d      <= res_nxt;
          barrow <= dig_bout;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Signed overflow: borrow into the MSB disagrees with the borrow out of it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ovf <= 1'b0;
    else if (last) ovf <= dig_bmsb ^ dig_bout;
  end
`else
  logic unused_bmsb;
  assign unused_bmsb = dig_bmsb;
`endif

endmodule
